// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard, forwarding and stall/flush controller for the five-stage MIPS core
// (F, D, E, M, W). This block is the only source of pipeline-register holds
// and bubbles. It also supervises the variable-latency data-memory access.
//
// Parameters
//   MEM_TIMEOUT  maximum stalled cycles for one data-memory access before the
//                pipeline is forcibly released (must be >= 2)
//   CNT_W        width of the saturating stall-cycle counter
//
// Ports
//   clk                         core clock, all state on the rising edge
//   rst                         asynchronous, active-low reset
//   rsD, rtD                    source registers of the instruction in D
//   rsE, rtE                    source registers of the instruction in E
//   writeRegE/M/W               destination register per stage
//   regWeE/M/W                  register-file write enable per stage
//   memToRegE, memToRegM        instruction in that stage is a load
//   branchD                     D instruction compares rs/rt (beq, bne, jr)
//   redirectD                   D resolved a taken branch/j/jal/jr
//   memReqM                     load/store in M is accessing data memory
//   dmemAck                     data memory completes the access this cycle
//   stallF/D/E/M                hold the pipeline register of that stage
//   flushD/E/W                  load a bubble into that stage register
//   fwdAE, fwdBE                E operand select: 00 regfile, 01 W result,
//                               10 M ALU result
//   fwdAD, fwdBD                D compare operand taken from the M ALU result
//   memErr                      sticky: a data-memory access timed out
//   stallCount                  cycles with stallF=1, saturating at all-ones
//   dbgState                    current FSM state (0 = RUN, 1 = MEM_WAIT)
//
// Memory handshake: memReqM acts as "valid" and dmemAck as "ready". An access
// completes in the cycle where both are high. While memReqM is high without
// dmemAck the whole pipeline is frozen, up to MEM_TIMEOUT cycles. After that
// the access is abandoned, memErr is set and the pipeline moves again.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeRegE,
    input  logic [4:0]       writeRegM,
    input  logic [4:0]       writeRegW,
    input  logic             regWeE,
    input  logic             regWeM,
    input  logic             regWeW,
    input  logic             memToRegE,
    input  logic             memToRegM,
    input  logic             branchD,
    input  logic             redirectD,
    input  logic             memReqM,
    input  logic             dmemAck,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic [1:0]       fwdAE,
    output logic [1:0]       fwdBE,
    output logic             fwdAD,
    output logic             fwdBD,
    output logic             memErr,
    output logic [CNT_W-1:0] stallCount,
    output logic             dbgState
);

    localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_VAL = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE    = WAIT_W'(1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_cnt_nxt;
    logic              mem_err_nxt;

    logic              timeout_hit;
    logic              mem_stall;
    logic              load_use;
    logic              branch_stall;
    logic              haz_stall;

    // A producer matches a consumer only when it writes a real register;
    // $0 is hard-wired to zero and never creates a dependency.
    function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
        return (dst != 5'd0) && (dst == src);
    endfunction

    // ---------------------------------------------------------------------
    // Operand forwarding. M is younger than W, so M wins when both match.
    // ---------------------------------------------------------------------
    always_comb begin
        fwdAE = 2'b00;
        if (regWeM && reg_hit(writeRegM, rsE)) begin
            fwdAE = 2'b10;
        end else if (regWeW && reg_hit(writeRegW, rsE)) begin
            fwdAE = 2'b01;
        end

        fwdBE = 2'b00;
        if (regWeM && reg_hit(writeRegM, rtE)) begin
            fwdBE = 2'b10;
        end else if (regWeW && reg_hit(writeRegW, rtE)) begin
            fwdBE = 2'b01;
        end
    end

    // Branch comparison in D can only take an already computed ALU result
    // from M. W results reach D through the register file write-first path.
    assign fwdAD = regWeM && reg_hit(writeRegM, rsD);
    assign fwdBD = regWeM && reg_hit(writeRegM, rtD);

    // ---------------------------------------------------------------------
    // Hazard detection
    // ---------------------------------------------------------------------
    // A load in E has no data until after M, so a dependent D instruction
    // waits one cycle. The bubble in E lets the load move to M, and the
    // value then reaches E through the W forwarding path.
    assign load_use = memToRegE && regWeE &&
                      (reg_hit(writeRegE, rsD) || reg_hit(writeRegE, rtD));

    // A branch compares in D. It must wait while its operand is still being
    // computed in E, or while a load that produces it is still in M.
    assign branch_stall = branchD &&
                          ((regWeE && (reg_hit(writeRegE, rsD) || reg_hit(writeRegE, rtD))) ||
                           (memToRegM && (reg_hit(writeRegM, rsD) || reg_hit(writeRegM, rtD))));

    assign haz_stall = load_use || branch_stall;

    // ---------------------------------------------------------------------
    // Data-memory wait supervision
    // ---------------------------------------------------------------------
    // wait_cnt counts the cycles already stalled for the current access.
    // When it reaches MEM_TIMEOUT, the access is released even without an ack.
    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == TIMEOUT_VAL);
    assign mem_stall   = memReqM && !dmemAck && !timeout_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            memErr   <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            memErr   <= mem_err_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = memErr;

        case (state)
            RUN: begin
                if (mem_stall) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (dmemAck || !memReqM) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else if (timeout_hit) begin
                    // The release cycle itself is not stalled. The error is
                    // recorded on the edge that ends it.
                    mem_err_nxt  = 1'b1;
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                end else begin
                    wait_cnt_nxt = wait_cnt + WAIT_ONE;
                end
            end
            default: begin
                state_nxt    = RUN;
                wait_cnt_nxt = '0;
            end
        endcase
    end

    assign dbgState = state;

    // ---------------------------------------------------------------------
    // Stall / flush strobes, in priority order
    // ---------------------------------------------------------------------
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        flushW = 1'b0;

        if (mem_stall) begin
            // The whole front of the pipe is frozen behind M. W receives a
            // bubble so the stalled M instruction does not retire twice.
            // Any pending D hazard is re-evaluated after the release.
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (haz_stall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else if (redirectD) begin
            // No delay slot: the sequential fetch behind a taken redirect is
            // squashed. During a stall D is held, so the redirect is seen
            // again once the stall clears.
            flushD = 1'b1;
        end
    end

    // ---------------------------------------------------------------------
    // Saturating stall-cycle counter
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCount <= '0;
        end else if (stallF && (stallCount != {CNT_W{1'b1}})) begin
            stallCount <= stallCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed bench for hazard_ctrl (MEM_TIMEOUT = 4). Each cycle the driver
// applies a hand-written input vector shortly after the rising edge and
// pushes the hand-computed expected outputs into exp_q. A separate monitor
// pops one entry on every falling edge and compares it with the DUT outputs.
// The expected stall counter is carried along as a running total of the
// expected stallF values.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 32;
    localparam int W           = 15 + CNT_W;

    localparam logic [3:0] S0 = 4'b0000;  // no stalls
    localparam logic [3:0] SH = 4'b1100;  // hazard stall: F, D
    localparam logic [3:0] SM = 4'b1111;  // memory stall: F, D, E, M
    localparam logic [2:0] F0 = 3'b000;   // flush order: {D, E, W}
    localparam logic [2:0] FD = 3'b100;
    localparam logic [2:0] FE = 3'b010;
    localparam logic [2:0] FW = 3'b001;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [4:0]       rsD, rtD, rsE, rtE;
    logic [4:0]       writeRegE, writeRegM, writeRegW;
    logic             regWeE, regWeM, regWeW;
    logic             memToRegE, memToRegM;
    logic             branchD, redirectD, memReqM, dmemAck;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic [1:0]       fwdAE, fwdBE;
    logic             fwdAD, fwdBD;
    logic             memErr;
    logic [CNT_W-1:0] stallCount;
    logic             dbgState;

    hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rsD        (rsD),
        .rtD        (rtD),
        .rsE        (rsE),
        .rtE        (rtE),
        .writeRegE  (writeRegE),
        .writeRegM  (writeRegM),
        .writeRegW  (writeRegW),
        .regWeE     (regWeE),
        .regWeM     (regWeM),
        .regWeW     (regWeW),
        .memToRegE  (memToRegE),
        .memToRegM  (memToRegM),
        .branchD    (branchD),
        .redirectD  (redirectD),
        .memReqM    (memReqM),
        .dmemAck    (dmemAck),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .flushW     (flushW),
        .fwdAE      (fwdAE),
        .fwdBE      (fwdBE),
        .fwdAD      (fwdAD),
        .fwdBD      (fwdBD),
        .memErr     (memErr),
        .stallCount (stallCount),
        .dbgState   (dbgState)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_cmp;
    int           n_bad;
    logic [CNT_W-1:0] exp_cnt;

    logic [W-1:0] act;
    assign act = {stallF, stallD, stallE, stallM, flushD, flushE, flushW,
                  fwdAE, fwdBE, fwdAD, fwdBD, memErr, dbgState, stallCount};

    always @(negedge clk) begin
        logic [W-1:0] e;
        string        nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", nm, act, e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeRegE = 5'd0; writeRegM = 5'd0; writeRegW = 5'd0;
        regWeE = 1'b0; regWeM = 1'b0; regWeW = 1'b0;
        memToRegE = 1'b0; memToRegM = 1'b0;
        branchD = 1'b0; redirectD = 1'b0; memReqM = 1'b0; dmemAck = 1'b0;
    endtask

    // Queue the expected outputs for the current cycle, then advance the
    // expected stall counter by this cycle's expected stallF.
    task automatic chk(input string nm, input logic [3:0] st, input logic [2:0] fl,
                       input logic [1:0] fae, input logic [1:0] fbe,
                       input logic fad, input logic fbd,
                       input logic merr, input logic sta);
        exp_q.push_back({st, fl, fae, fbe, fad, fbd, merr, sta, exp_cnt});
        name_q.push_back(nm);
        if (st[3] && rst && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
    endtask

    task automatic do_reset();
        tick();
        clr();
        rst = 1'b0;
        exp_cnt = '0;
        chk("reset", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        chk("post_reset", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        exp_cnt = '0;
        rst     = 1'b0;
        clr();
        repeat (2) @(posedge clk);

        do_reset();

        // Forwarding priority and register-0 / write-enable gating
        tick(); clr();
        regWeM = 1'b1; regWeW = 1'b1; writeRegM = 5'd5; writeRegW = 5'd5; rsE = 5'd5;
        chk("fwd_m_over_w", S0, F0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        writeRegM = 5'd0; rtE = 5'd5;
        chk("fwd_w", S0, F0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rsE = 5'd0;
        chk("fwd_rs_zero", S0, F0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        writeRegM = 5'd6; rtE = 5'd6; rsD = 5'd6; rtD = 5'd5;
        chk("fwd_b_m_and_d", S0, F0, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        regWeM = 1'b0;
        chk("fwd_we_gate", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Load-use: one bubble, then E has advanced
        do_reset();
        tick(); clr();
        memToRegE = 1'b1; regWeE = 1'b1; writeRegE = 5'd8; rtD = 5'd8;
        chk("load_use", SH, FE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        chk("load_use_done", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        memToRegE = 1'b1; regWeE = 1'b1;
        chk("load_use_r0", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch on a load: two stall cycles (load in E, then in M)
        tick(); clr();
        branchD = 1'b1; rsD = 5'd9; memToRegE = 1'b1; regWeE = 1'b1; writeRegE = 5'd9;
        chk("br_load_e", SH, FE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        branchD = 1'b1; rsD = 5'd9; memToRegM = 1'b1; regWeM = 1'b1; writeRegM = 5'd9;
        chk("br_load_m", SH, FE, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        branchD = 1'b1; rsD = 5'd9; regWeW = 1'b1; writeRegW = 5'd9;
        chk("br_load_done", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Branch on an ALU result: one stall, then forwarded from M
        tick(); clr();
        branchD = 1'b1; rtD = 5'd7; regWeE = 1'b1; writeRegE = 5'd7;
        chk("br_alu_e", SH, FE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        branchD = 1'b1; rtD = 5'd7; regWeM = 1'b1; writeRegM = 5'd7;
        chk("br_alu_fwd", S0, F0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(); clr();
        redirectD = 1'b1;
        chk("redirect", S0, FD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Memory wait with ack three cycles after the request
        for (int i = 0; i < 3; i++) begin
            tick(); clr();
            memReqM = 1'b1;
            chk("mem_wait", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, (i != 0));
        end
        tick(); clr();
        memReqM = 1'b1; dmemAck = 1'b1;
        chk("mem_ack", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); clr();
        chk("mem_back_run", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Ack in the same cycle as the request: no stall
        tick(); clr();
        memReqM = 1'b1; dmemAck = 1'b1;
        chk("mem_ack_now", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        chk("mem_ack_now_run", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Timeout: MEM_TIMEOUT stall cycles, release, sticky error
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            tick(); clr();
            memReqM = 1'b1;
            chk("tmo_stall", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, (i != 0));
        end
        tick(); clr();
        memReqM = 1'b1;
        chk("tmo_release", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); clr();
        chk("tmo_err_set", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); clr();
        chk("tmo_err_sticky", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();

        // Reset while in MEM_WAIT, with the request still pending
        tick(); clr();
        memReqM = 1'b1;
        chk("rw_stall0", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rw_stall1", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        exp_cnt = '0;
        chk("rw_in_reset", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        chk("rw_restart0", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rw_restart1", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        dmemAck = 1'b1;
        chk("rw_ack", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); clr();
        chk("rw_run", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Priority: memStall over hazard over redirect
        tick(); clr();
        memReqM = 1'b1; memToRegE = 1'b1; regWeE = 1'b1; writeRegE = 5'd8; rtD = 5'd8;
        redirectD = 1'b1;
        chk("prio_mem", SM, FW, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        dmemAck = 1'b1;
        chk("prio_haz", SH, FE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(); clr();
        redirectD = 1'b1;
        chk("prio_redirect", S0, FD, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); clr();
        chk("prio_idle", S0, F0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);

        // Drain, bounded
        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
